alu_op_scheduler: RTL and testbench

//  Issue controller in front of the ALU. Accepts one op at a time over a valid/ready handshake and holds

---
 rtl/alu_op_scheduler_pkg.sv | 25 ++
 rtl/alu_op_scheduler_if.sv | 29 ++
 rtl/alu_op_scheduler_lat_lookup.sv | 33 +++
 rtl/alu_op_scheduler.sv | 144 ++++++++++++++
 tb/tb_alu_op_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_scheduler_pkg.sv
// Shared opcode map and scheduler state encoding for the ALU issue controller.
package alu_op_scheduler_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_MUL  = 6'd2;
  localparam logic [5:0] OP_DIV  = 6'd3;
  localparam logic [5:0] OP_SLL  = 6'd4;
  localparam logic [5:0] OP_SRL  = 6'd5;
  localparam logic [5:0] OP_AND  = 6'd6;
  localparam logic [5:0] OP_OR   = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLT  = 6'd9;
  localparam logic [5:0] OP_ADDF = 6'd10;
  localparam logic [5:0] OP_SUBF = 6'd11;
  localparam logic [5:0] OP_MULF = 6'd12;
  localparam logic [5:0] OP_DIVF = 6'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Issue, ALU-side and result handshake signals of the ALU op scheduler.
interface alu_op_scheduler_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_shamt;
  logic [5:0]  alu_con;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        stall;

  modport master (
    output in_valid, in_op, in_a, in_b, in_shamt, alu_out, out_ready,
    input  in_ready, alu_con, alu_a, alu_b, alu_shamt, out_valid, out_data, out_err, stall
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_shamt, alu_out, out_ready,
    output in_ready, alu_con, alu_a, alu_b, alu_shamt, out_valid, out_data, out_err, stall
  );
endinterface

// File: rtl/alu_op_scheduler_lat_lookup.sv
// Combinational opcode decode: legality and execution latency in cycles.
module alu_lat_lookup
  import alu_op_scheduler_pkg::*;
#(
  parameter int LAT_INT = 1,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 4,
  parameter int LAT_FP  = 6,
  parameter int CNT_W   = 4
) (
  input  logic [5:0]       i_op,
  output logic             o_legal,
  output logic [CNT_W-1:0] o_lat
);

  // Opcode to latency map; illegal opcodes run for a single cycle
  always_comb begin
    o_legal = 1'b1;
    o_lat   = LAT_INT[CNT_W-1:0];
    case (i_op)
      OP_ADD, OP_SUB, OP_SLL, OP_SRL,
      OP_AND, OP_OR, OP_XOR, OP_SLT:     o_lat = LAT_INT[CNT_W-1:0];
      OP_MUL:                            o_lat = LAT_MUL[CNT_W-1:0];
      OP_DIV:                            o_lat = LAT_DIV[CNT_W-1:0];
      OP_ADDF, OP_SUBF, OP_MULF, OP_DIVF: o_lat = LAT_FP[CNT_W-1:0];
      default: begin
        o_legal = 1'b0;
        o_lat   = {{(CNT_W-1){1'b0}}, 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// ALU issue controller: holds one op on the ALU inputs for its latency, then buffers the result.
module alu_op_scheduler
  import alu_op_scheduler_pkg::*;
#(
  parameter int LAT_INT = 1,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 4,
  parameter int LAT_FP  = 6,
  parameter int CNT_W   = 4
) (
  input logic               clk,
  input logic               rst,
  alu_op_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_legal;
  logic [5:0]       r_alu_con;
  logic [31:0]      r_alu_a;
  logic [31:0]      r_alu_b;
  logic [4:0]       r_alu_shamt;
  logic [31:0]      r_out_data;
  logic             r_out_valid;
  logic             r_out_err;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic             w_in_ready;
  logic             w_legal;
  logic [CNT_W-1:0] w_lat;

  alu_lat_lookup #(
    .LAT_INT (LAT_INT),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_FP  (LAT_FP),
    .CNT_W   (CNT_W)
  ) u_lat (
    .i_op    (bus.in_op),
    .o_legal (w_legal),
    .o_lat   (w_lat)
  );

  // Next-state and handshake decode; DONE frees the slot in the same cycle the result is taken
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (r_cnt == CNT_ZERO) begin
          w_capture    = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_in_ready = 1'b1;
          w_release  = 1'b1;
          if (bus.in_valid) begin
            w_accept     = 1'b1;
            w_next_state = ST_EXEC;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Operand hold registers and latency countdown, loaded only on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= CNT_ZERO;
      r_legal     <= 1'b0;
      r_alu_con   <= 6'd0;
      r_alu_a     <= 32'd0;
      r_alu_b     <= 32'd0;
      r_alu_shamt <= 5'd0;
    end else if (w_accept) begin
      r_cnt       <= w_lat - CNT_ONE;
      r_legal     <= w_legal;
      r_alu_con   <= bus.in_op;
      r_alu_a     <= bus.in_a;
      r_alu_b     <= bus.in_b;
      r_alu_shamt <= bus.in_shamt;
    end else if ((r_state == ST_EXEC) && (r_cnt != CNT_ZERO)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // One-entry result buffer; illegal ops report zero data with the error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data  <= 32'd0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_data  <= r_legal ? bus.alu_out : 32'd0;
      r_out_err   <= ~r_legal;
      r_out_valid <= 1'b1;
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.stall     = bus.in_valid & ~w_in_ready;
  assign bus.alu_con   = r_alu_con;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_shamt = r_alu_shamt;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: ALU stand-in, cycle model with result queue, and directed scenarios.
module tb_alu_op_scheduler;
  import alu_op_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_op_scheduler_if bus();

  alu_op_scheduler #(
    .LAT_INT (1), .LAT_MUL (2), .LAT_DIV (4), .LAT_FP (6), .CNT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ops_issued = 0;
  int n_acc = 0;
  int n_cons = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (op)
      6'd0:  return a + b;
      6'd1:  return a - b;
      6'd2:  return a * b;
      6'd3:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      6'd4:  return a << sh;
      6'd5:  return a >> sh;
      6'd6:  return a & b;
      6'd7:  return a | b;
      6'd8:  return a ^ b;
      6'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd10, 6'd11, 6'd12, 6'd13: return a ^ ~b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] op);
    if (op == 6'd2) return 2;
    if (op == 6'd3) return 4;
    if (op >= 6'd10 && op <= 6'd13) return 6;
    return 1;
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_con, bus.alu_a, bus.alu_b, bus.alu_shamt);

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } res_t;

  // Model: results in acceptance order; the outstanding op becomes visible LAT edges after accept
  initial begin
    res_t        q[$];
    res_t        r;
    logic        m_inflight, m_visible, exp_ready;
    int          m_left;
    logic [5:0]  m_con;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_sh;
    m_inflight = 1'b0; m_visible = 1'b0; m_left = 0;
    m_con = 6'd0; m_a = 32'd0; m_b = 32'd0; m_sh = 5'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
        chk("rst_alu_con", {26'd0, bus.alu_con}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_alu_shamt", {27'd0, bus.alu_shamt}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        q.delete();
        m_inflight = 1'b0; m_visible = 1'b0; m_left = 0;
        m_con = 6'd0; m_a = 32'd0; m_b = 32'd0; m_sh = 5'd0;
        n_acc = 0; n_cons = 0;
      end else begin
        exp_ready = !m_inflight || (m_visible && bus.out_ready);
        chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, m_visible});
        chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        chk("m_stall", {31'd0, bus.stall}, {31'd0, bus.in_valid & ~exp_ready});
        chk("m_alu_con", {26'd0, bus.alu_con}, {26'd0, m_con});
        chk("m_alu_a", bus.alu_a, m_a);
        chk("m_alu_b", bus.alu_b, m_b);
        chk("m_alu_shamt", {27'd0, bus.alu_shamt}, {27'd0, m_sh});
        if (m_visible && q.size() > 0) begin
          chk("m_out_data", bus.out_data, q[0].data);
          chk("m_out_err", {31'd0, bus.out_err}, {31'd0, q[0].err});
        end
        if (m_visible && bus.out_ready) begin
          if (q.size() > 0) q.delete(0);
          m_visible = 1'b0; m_inflight = 1'b0; n_cons++;
        end else if (m_inflight && !m_visible) begin
          m_left--;
          if (m_left == 0) m_visible = 1'b1;
        end
        if (bus.in_valid && exp_ready) begin
          r.err  = (bus.in_op > 6'd13);
          r.data = r.err ? 32'd0 : alu_fn(bus.in_op, bus.in_a, bus.in_b, bus.in_shamt);
          q.push_back(r);
          m_left = lat_of(bus.in_op); m_inflight = 1'b1;
          m_con = bus.in_op; m_a = bus.in_a; m_b = bus.in_b; m_sh = bus.in_shamt;
          n_acc++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    int n;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_shamt = sh;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    ops_issued++;
  endtask

  // Returns at the negedge where out_valid is seen; cyc counts earlier negedges
  task automatic wait_valid(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      cyc++;
      if (cyc > 50) begin
        chk("valid_timeout", {31'd0, bus.out_valid}, 32'd1);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    int sc;
    bit done;
    logic [5:0] rop;
    bus.in_valid = 1'b0; bus.in_op = 6'd0; bus.in_a = 32'd0; bus.in_b = 32'd0;
    bus.in_shamt = 5'd0; bus.out_ready = 1'b0;
    #2 rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);

    // Reset in the middle of a DIV
    do_op(OP_DIV, 32'd50, 32'd5, 5'd0);
    step(1);
    rst = 1'b0;
    #1;
    chk("t1_alu_a", bus.alu_a, 32'd0);
    chk("t1_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step(2);
    rst = 1'b1;
    ops_issued = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_no_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t1_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    step(1);

    // ADD 5+7, single-cycle latency
    bus.out_ready = 1'b1;
    do_op(OP_ADD, 32'd5, 32'd7, 5'd0);
    @(negedge clk); chk("t2_early", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk); chk("t2_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t2_data", bus.out_data, 32'd12);
    chk("t2_err", {31'd0, bus.out_err}, 32'd0);
    step(2);

    // DIV 100/7 with a follow-up op waiting: four stall cycles, stable operands
    do_op(OP_DIV, 32'd100, 32'd7, 5'd0);
    bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_a = 32'd1; bus.in_b = 32'd1;
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      sc++;
      chk("t3_alu_a", bus.alu_a, 32'd100);
      chk("t3_alu_b", bus.alu_b, 32'd7);
    end
    chk("t3_stall_cycles", sc, 32'd4);
    chk("t3_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t3_data", bus.out_data, 32'd14);
    step(1);
    bus.in_valid = 1'b0;
    ops_issued++;
    step(4);

    // MUL 3*4 held under back-pressure while SUB 9-2 waits
    bus.out_ready = 1'b0;
    do_op(OP_MUL, 32'd3, 32'd4, 5'd0);
    wait_valid(cyc);
    chk("t4_mul_latency", cyc, 32'd2);
    step(1);
    bus.in_valid = 1'b1; bus.in_op = OP_SUB; bus.in_a = 32'd9; bus.in_b = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("t4_held", bus.out_data, 32'd12);
    end
    step(1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_comb", {31'd0, bus.in_ready}, 32'd1);
    chk("t4_data12", bus.out_data, 32'd12);
    step(1);
    bus.in_valid = 1'b0;
    ops_issued++;
    @(negedge clk); chk("t4_exec", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk); chk("t4_sub", bus.out_data, 32'd7);
    step(1);

    // Illegal opcode then a legal ADD
    do_op(6'd20, 32'h55, 32'h66, 5'd3);
    @(negedge clk); chk("t5_alu_con", {26'd0, bus.alu_con}, 32'd20);
    @(negedge clk); chk("t5_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("t5_data", bus.out_data, 32'd0);
    chk("t5_err", {31'd0, bus.out_err}, 32'd1);
    step(1);
    do_op(OP_ADD, 32'd2, 32'd3, 5'd0);
    @(negedge clk);
    @(negedge clk); chk("t5_add_err", {31'd0, bus.out_err}, 32'd0);
    chk("t5_add_data", bus.out_data, 32'd5);
    step(1);

    // FP op: longest latency
    do_op(OP_ADDF, 32'd1, 32'd2, 5'd0);
    wait_valid(cyc);
    chk("t5_fp_latency", cyc, 32'd6);
    step(2);

    // Random integer stream with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          rop = 6'($urandom_range(0, 9));
          do_op(rop, 32'($urandom_range(0, 1000)), 32'($urandom_range(1, 50)),
                5'($urandom_range(0, 31)));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    step(20);
    chk("t6_accepted", n_acc, ops_issued);
    chk("t6_consumed", n_cons, ops_issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
